// File: rtl/cla_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead adder.
package cla_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Nibble-index register width; a single-nibble adder still needs one bit.
    function automatic int unsigned cla_idx_w(input int unsigned nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage

// File: rtl/cla_lookahead_unit.sv
// 4-bit lookahead carry unit: every carry is a two-level sum of products of p/g/c0.
module cla_lookahead_unit (
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       c0,
    output logic [3:1] c,
    output logic       c4,
    output logic       g_blk,
    output logic       p_blk
);

    assign c[1]  = g[0] | (p[0] & c0);
    assign c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);

    assign g_blk = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign p_blk = &p;
    assign c4    = g_blk | (p_blk & c0);

endmodule

// File: rtl/cla_serial_adder.sv
// Multi-cycle adder: resolves one nibble per cycle through a lookahead unit,
// linking nibbles with a registered carry.
module cla_serial_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NIB   = WIDTH / NIB_W;
    localparam int unsigned IDX_W = cla_idx_w(NIB);

    if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
        $error("cla_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              carry_q, cout_q;
    logic [IDX_W-1:0]  idx_q;
    logic [NIB_W-1:0]  a_n, b_n, p, g, s;
    logic [3:1]        c;
    logic              c4, g_blk, p_blk;
    logic              accept, last;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    assign accept = in_valid & in_ready;
    assign last   = (idx_q == IDX_W'(NIB - 1));

    assign a_n = NIB_W'(a_q >> (int'(idx_q) * NIB_W));
    assign b_n = NIB_W'(b_q >> (int'(idx_q) * NIB_W));
    assign p   = a_n ^ b_n;
    assign g   = a_n & b_n;
    assign s   = p ^ {c, carry_q};

    cla_lookahead_unit u_lookahead (
        .p     (p),
        .g     (g),
        .c0    (carry_q),
        .c     (c),
        .c4    (c4),
        .g_blk (g_blk),
        .p_blk (p_blk)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= cin;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    carry_q <= c4;
                    idx_q   <= idx_q + 1'b1;
                    for (int unsigned k = 0; k < NIB; k++) begin
                        if (idx_q == IDX_W'(k)) sum_q[k*NIB_W +: NIB_W] <= s;
                    end
                    // Same value as c4, formed from the block generate/propagate pair.
                    if (last) cout_q <= g_blk | (p_blk & carry_q);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_serial_adder.sv
// Directed-vector and random bench for cla_serial_adder at WIDTH = 16 and WIDTH = 4.
module tb_cla_serial_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, cin, out_ready;
    logic [15:0] a, b;
    logic        in_ready, out_valid, cout;
    logic [15:0] sum;

    logic        in_valid4, cin4, out_ready4;
    logic [3:0]  a4, b4;
    logic        in_ready4, out_valid4, cout4;
    logic [3:0]  sum4;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    cla_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    cla_serial_adder #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Caller is #1 past an edge with the DUT idle; returns result, latency and post-release readiness.
    task automatic op16(input logic [15:0] ai, input logic [15:0] bi, input logic ci, input bit rnd,
                        output logic [15:0] s, output logic co, output int lat, output logic rdy);
        in_valid = 1'b1; a = ai; b = bi; cin = ci;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            if (rnd) out_ready = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        s = sum; co = cout;
        if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        rdy = in_ready & ~out_valid;
    endtask

    task automatic op4(input logic [3:0] ai, input logic [3:0] bi, input logic ci,
                       output logic [3:0] s, output logic co, output int lat);
        in_valid4 = 1'b1; a4 = ai; b4 = bi; cin4 = ci;
        @(posedge clk); #1;
        in_valid4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
        lat = 0;
        while (out_valid4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s = sum4; co = cout4;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        out_ready4 = 1'b1;
        @(posedge clk); #1;
        out_ready4 = 1'b0;
    endtask

    initial begin
        logic [15:0] s;
        logic [3:0]  s4;
        logic        co, rdy;
        logic [16:0] ref17;
        logic [4:0]  ref5;
        logic [15:0] ra, rb;
        logic [3:0]  ra4, rb4;
        logic        rc;
        int          lat;
        bit          seen;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[5] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[6] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
        vecs[8] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; out_ready4 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset out_valid", out_valid, 1'b0);
        check("reset sum", sum, 16'h0);
        check("reset cout", cout, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset4 in_ready", in_ready4, 1'b1);

        for (int i = 0; i < 9; i++) begin
            op16(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, s, co, lat, rdy);
            check($sformatf("vec%0d sum", i), s, vecs[i].s);
            check($sformatf("vec%0d cout", i), co, vecs[i].co);
            check($sformatf("vec%0d latency", i), lat, 4);
            check($sformatf("vec%0d ready after done", i), rdy, 1'b1);
        end

        // Backpressure, with in_valid noise throughout RUN and DONE.
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111; cin = 1'b0;
        @(posedge clk); #1;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
            out_ready = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        out_ready = 1'b0;
        check("bp latency", lat, 4);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            @(posedge clk); #1;
            check("bp sum held", sum, 16'h2345);
            check("bp cout held", cout, 1'b0);
            check("bp in_ready low", in_ready, 1'b0);
            check("bp out_valid held", out_valid, 1'b1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp release out_valid", out_valid, 1'b0);
        check("bp release in_ready", in_ready, 1'b1);

        // Reset on the second RUN cycle discards the operation.
        in_valid = 1'b1; a = 16'hABCD; b = 16'h1234; cin = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrun in_ready", in_ready, 1'b1);
        check("midrun out_valid", out_valid, 1'b0);
        check("midrun sum", sum, 16'h0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        check("midrun no out_valid", seen, 1'b0);
        op16(16'h0001, 16'h0001, 1'b0, 1'b0, s, co, lat, rdy);
        check("post-reset sum", s, 16'h0002);
        check("post-reset cout", co, 1'b0);
        check("post-reset latency", lat, 4);

        for (int i = 0; i < 2000; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
            ref17 = 17'(ra) + 17'(rb) + 17'(rc);
            op16(ra, rb, rc, 1'b1, s, co, lat, rdy);
            check("rand16 sum", s, ref17[15:0]);
            check("rand16 cout", co, ref17[16]);
            check("rand16 latency", lat, 4);
        end

        op4(4'hF, 4'h1, 1'b0, s4, co, lat);
        check("w4 F+1 sum", s4, 4'h0);
        check("w4 F+1 cout", co, 1'b1);
        check("w4 latency", lat, 1);
        op4(4'h7, 4'h8, 1'b1, s4, co, lat);
        check("w4 7+8+1 sum", s4, 4'h0);
        check("w4 7+8+1 cout", co, 1'b1);
        op4(4'h3, 4'h4, 1'b0, s4, co, lat);
        check("w4 3+4 sum", s4, 4'h7);
        check("w4 3+4 cout", co, 1'b0);
        for (int i = 0; i < 1000; i++) begin
            ra4 = 4'($urandom); rb4 = 4'($urandom); rc = 1'($urandom);
            ref5 = 5'(ra4) + 5'(rb4) + 5'(rc);
            op4(ra4, rb4, rc, s4, co, lat);
            check("rand4 sum", s4, ref5[3:0]);
            check("rand4 cout", co, ref5[4]);
            check("rand4 latency", lat, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
